// File: rtl/sphere_frame_loader.sv
// JTAG-side frame loader: validates a header, assembles two sphere operands,
// launches the collision core under a watchdog and buffers its results.
module sphere_frame_loader #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic         tck,
   input  logic         reset,
   input  logic [31:0]  rx_data,
   input  logic         rx_valid,
   output logic [127:0] sphere_a,
   output logic [127:0] sphere_b,
   output logic         core_start,
   input  logic         core_done,
   input  logic [31:0]  result_word,
   input  logic         result_valid,
   output logic [31:0]  tx_data,
   input  logic         tx_pop,
   output logic         busy
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int WDW = $clog2(TIMEOUT_CYCLES);

   localparam logic [31:0]  HDR_LOAD  = 32'hA500_0008;
   localparam logic [31:0]  HDR_CLEAR = 32'hA500_0000;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t state, state_n;

   logic [2:0]     idx;
   logic [WDW-1:0] wd;
   logic [7:0]     err_cnt;
   logic           flag_timeout, flag_ovf, flag_drop;

   logic [31:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic [CW-1:0]  count;

   logic hdr_load, hdr_clear, hdr_bad, load_we, wd_expire;
   logic rx_drop_set, push_req, fifo_full, fifo_empty, do_push, do_pop, ovf_set;

   always_ff @(posedge tck) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      hdr_load  = 1'b0;
      hdr_clear = 1'b0;
      hdr_bad   = 1'b0;
      load_we   = 1'b0;
      wd_expire = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data == HDR_LOAD) begin
                  hdr_load = 1'b1;
                  state_n  = S_LOAD;
               end else if (rx_data == HDR_CLEAR) begin
                  hdr_clear = 1'b1;
               end else begin
                  hdr_bad = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (rx_valid) begin
               load_we = 1'b1;
               if (idx == 3'd7) state_n = S_START;
            end
         end
         S_START: state_n = S_WAIT;
         S_WAIT: begin
            if (core_done) begin
               state_n = S_IDLE;
            end else if (wd == WD_LAST) begin
               wd_expire = 1'b1;
               state_n   = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign core_start  = (state == S_START);
   assign busy        = (state != S_IDLE);
   assign rx_drop_set = rx_valid && (state == S_START || state == S_WAIT);

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_FULL);
   assign push_req   = result_valid && (state == S_WAIT);
   assign do_pop     = tx_pop && !fifo_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push    = push_req && (!fifo_full || do_pop);
   assign ovf_set    = push_req && fifo_full && !do_pop;

   always_ff @(posedge tck) begin
      if (reset) begin
         idx          <= '0;
         wd           <= '0;
         sphere_a     <= '0;
         sphere_b     <= '0;
         err_cnt      <= '0;
         flag_timeout <= 1'b0;
         flag_ovf     <= 1'b0;
         flag_drop    <= 1'b0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
      end else begin
         if (hdr_load) idx <= '0;
         if (load_we) begin
            if (!idx[2]) sphere_a[{idx[1:0], 5'b0} +: 32] <= rx_data;
            else         sphere_b[{idx[1:0], 5'b0} +: 32] <= rx_data;
            idx <= idx + 3'd1;
         end

         if (state == S_START)     wd <= '0;
         else if (state == S_WAIT) wd <= wd + WDW'(1);

         if (hdr_clear) begin
            err_cnt      <= '0;
            flag_timeout <= 1'b0;
            flag_ovf     <= 1'b0;
            flag_drop    <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
         end else begin
            if (hdr_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (wd_expire)   flag_timeout <= 1'b1;
            if (ovf_set)     flag_ovf     <= 1'b1;
            if (rx_drop_set) flag_drop    <= 1'b1;
            if (do_push)     wr_ptr       <= wr_ptr + PW'(1);
            if (do_pop)      rd_ptr       <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
         end
      end
   end

   // Storage array carries no reset; only pointers and count define contents.
   always_ff @(posedge tck) begin
      if (do_push && !hdr_clear) mem[wr_ptr] <= result_word;
   end

   always_comb begin
      if (fifo_empty)
         tx_data = {8'h5A, err_cnt, flag_timeout, flag_ovf, flag_drop,
                    5'b0, 2'b0, state, 4'b0};
      else
         tx_data = mem[rd_ptr];
   end

endmodule

// File: tb/tb_sphere_frame_loader.sv
// Directed bench for sphere_frame_loader: framing, results FIFO, errors,
// watchdog timeout and mid-frame reset.
module tb_sphere_frame_loader;

   localparam int TO = 32;
   localparam int FD = 8;

   logic         tck = 1'b0;
   logic         reset;
   logic [31:0]  rx_data;
   logic         rx_valid;
   logic [127:0] sphere_a, sphere_b;
   logic         core_start;
   logic         core_done;
   logic [31:0]  result_word;
   logic         result_valid;
   logic [31:0]  tx_data;
   logic         tx_pop;
   logic         busy;

   int tests = 0;
   int fails = 0;
   int start_cnt = 0;

   sphere_frame_loader #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
      .tck(tck), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .sphere_a(sphere_a), .sphere_b(sphere_b), .core_start(core_start),
      .core_done(core_done), .result_word(result_word),
      .result_valid(result_valid), .tx_data(tx_data), .tx_pop(tx_pop),
      .busy(busy)
   );

   always #5 tck = ~tck;

   always @(posedge tck) if (core_start === 1'b1) start_cnt++;

   function automatic logic [31:0] st(input logic [7:0] err, input logic to,
                                      input logic ovf, input logic drop,
                                      input logic [1:0] s);
      return {8'h5A, err, to, ovf, drop, 5'b0, 2'b0, s, 4'b0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic rx(input logic [31:0] w);
      rx_data = w; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
   endtask

   task automatic words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) rx(base + 32'(i));
   endtask

   task automatic res(input logic [31:0] w);
      result_word = w; result_valid = 1'b1; tick(); result_valid = 1'b0;
   endtask

   task automatic pop();
      tx_pop = 1'b1; tick(); tx_pop = 1'b0;
   endtask

   task automatic done();
      core_done = 1'b1; tick(); core_done = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rx_data = '0; rx_valid = 1'b0; core_done = 1'b0;
      result_word = '0; result_valid = 1'b0; tx_pop = 1'b0;
      tick(); tick();
      reset = 1'b0;

      chk("reset_tx", tx_data, 32'h5A00_0000);
      chk("reset_busy", busy, 1'b0);
      chk("reset_sa", sphere_a, 128'd0);
      chk("reset_sb", sphere_b, 128'd0);
      chk("reset_start", core_start, 1'b0);

      // Full frame: header then 1..8
      rx(32'hA500_0008);
      chk("load_busy", busy, 1'b1);
      chk("load_state", tx_data, st(8'd0, 0, 0, 0, 2'd1));
      words(32'd1, 7);
      chk("no_early_start", core_start, 1'b0);
      rx(32'd8);
      chk("start_pulse", core_start, 1'b1);
      chk("frame_sa", sphere_a, {32'd4, 32'd3, 32'd2, 32'd1});
      chk("frame_sb", sphere_b, {32'd8, 32'd7, 32'd6, 32'd5});
      tick();
      chk("start_gone", core_start, 1'b0);
      chk("wait_state", tx_data, st(8'd0, 0, 0, 0, 2'd3));
      chk("one_pulse", start_cnt, 1);
      chk("wait_busy", busy, 1'b1);

      // Results then completion
      res(32'h11);
      chk("head_first", tx_data, 32'h11);
      res(32'h22);
      done();
      chk("done_busy", busy, 1'b0);
      chk("rd0", tx_data, 32'h11);
      pop();
      chk("rd1", tx_data, 32'h22);
      pop();
      chk("rd_status", tx_data, st(8'd0, 0, 0, 0, 2'd0));
      pop();
      chk("pop_empty", tx_data, st(8'd0, 0, 0, 0, 2'd0));

      // Overflow and wrap; partial load keeps older fields
      rx(32'hA500_0008);
      words(32'h10, 2);
      chk("partial_sa", sphere_a, {32'd4, 32'd3, 32'h11, 32'h10});
      words(32'h12, 6);
      tick();
      for (int i = 0; i < 9; i++) res(32'h100 + 32'(i));
      chk("ovf_head", tx_data, 32'h100);
      pop(); pop(); pop();
      chk("wrap_head", tx_data, 32'h103);
      for (int i = 0; i < 3; i++) res(32'h200 + 32'(i));
      result_word = 32'h203; result_valid = 1'b1; tx_pop = 1'b1;
      tick();
      result_valid = 1'b0; tx_pop = 1'b0;
      chk("full_pushpop_head", tx_data, 32'h104);
      done();
      for (int i = 0; i < 4; i++) begin
         chk("drain_a", tx_data, 32'h104 + 32'(i));
         pop();
      end
      for (int i = 0; i < 4; i++) begin
         chk("drain_b", tx_data, 32'h200 + 32'(i));
         pop();
      end
      chk("ovf_status", tx_data, st(8'd0, 0, 1, 0, 2'd0));

      // Bad headers, then CLEAR flushes a non-empty FIFO
      rx(32'h1234_5678);
      rx(32'h1234_5678);
      chk("err_cnt2", tx_data, st(8'd2, 0, 1, 0, 2'd0));
      rx(32'hA500_0008);
      words(32'h30, 8);
      tick();
      res(32'h77);
      done();
      chk("res77", tx_data, 32'h77);
      rx(32'hA500_0000);
      chk("clear", tx_data, st(8'd0, 0, 0, 0, 2'd0));
      res(32'h99);
      chk("idle_res_ignored", tx_data, st(8'd0, 0, 0, 0, 2'd0));

      // Watchdog timeout with dropped rx words
      rx(32'hA500_0008);
      words(32'h40, 8);
      tick();
      rx(32'hDEAD_0001);
      rx(32'hA500_0008);
      for (int i = 0; i < TO - 3; i++) tick();
      chk("wd_not_yet", busy, 1'b1);
      tick();
      chk("wd_expired", busy, 1'b0);
      chk("timeout_status", tx_data, st(8'd0, 1, 0, 1, 2'd0));
      chk("wd_sa_intact", sphere_a, {32'h43, 32'h42, 32'h41, 32'h40});

      // Reset mid-frame
      start_cnt = 0;
      rx(32'hA500_0008);
      words(32'h50, 3);
      reset = 1'b1; rx_data = 32'h53; rx_valid = 1'b1;
      tick();
      reset = 1'b0; rx_valid = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx", tx_data, 32'h5A00_0000);
      chk("rst_sa", sphere_a, 128'd0);
      words(32'h54, 5);
      tick(); tick();
      chk("rst_no_start", start_cnt, 0);
      chk("rst_err", tx_data, st(8'd5, 0, 0, 0, 2'd0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
